dcache: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache between the 8-bit CPU data port and the 32-bit-block data memory.
- Consumes the CPU's READ/WRITE/ADDRESS/WRITEDATA requests and returns READDATA/BUSYWAIT.
- On a miss it runs block writeback and fetch transactions against main memory using a busywait handshake.

---
 rtl/dcache_if.sv | 26 ++
 rtl/dcache.sv | 159 +++++++++++++++
 tb/tb_dcache.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_if.sv
// CPU-side and memory-side signal bundle of the data cache.
// The slave modport is the cache; the master modport is the CPU plus main memory around it.
interface dcache_if;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  modport slave (
    input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

  modport master (
    output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );
endinterface

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache: 8-bit CPU port, 32-bit block memory port.
// Define DCACHE_STATS_EN to add saturating HIT_COUNT / MISS_COUNT outputs.
module dcache #(
  parameter int INDEX_BITS = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  dcache_if.slave     bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] HIT_COUNT,
  output logic [15:0] MISS_COUNT
`endif
);
  localparam int TAG_BITS = 6 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;
  state_t state_reg, state_next;

  logic [1:0]            offset;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  assign offset = bus.ADDRESS[1:0];
  assign index  = bus.ADDRESS[INDEX_BITS+1:2];
  assign tag    = bus.ADDRESS[7:INDEX_BITS+2];

  logic [LINES-1:0]    valid_reg;
  logic [LINES-1:0]    dirty_reg;
  logic [TAG_BITS-1:0] tag_mem [LINES];

  // The missing block address is latched so the fill lands in the right line even if the CPU lets go.
  logic [5:0]            miss_block_reg;
  logic [31:0]           fill_data_reg;
  logic [INDEX_BITS-1:0] miss_index;
  logic [TAG_BITS-1:0]   miss_tag;
  assign miss_index = miss_block_reg[INDEX_BITS-1:0];
  assign miss_tag   = miss_block_reg[5:INDEX_BITS];

  logic request, idle, hit, write_hit, miss_start;
  assign request    = bus.READ | bus.WRITE;
  assign idle       = (state_reg == IDLE);
  assign hit        = valid_reg[index] && (tag_mem[index] == tag);
  assign write_hit  = idle && bus.WRITE && hit;
  assign miss_start = idle && request && !hit;

  logic [7:0] lane_rd     [4];
  logic [7:0] lane_victim [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [LINES];
      always_ff @(posedge CLK) begin
        if (state_reg == UPDATE)
          lane_mem[miss_index] <= fill_data_reg[8*gi +: 8];
        else if (write_hit && (offset == 2'(gi)))
          lane_mem[index] <= bus.WRITEDATA;
      end
      assign lane_rd[gi]     = lane_mem[index];
      assign lane_victim[gi] = lane_mem[miss_index];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_reg <= '0;
      dirty_reg <= '0;
    end else if (state_reg == UPDATE) begin
      valid_reg[miss_index] <= 1'b1;
      dirty_reg[miss_index] <= 1'b0;
    end else if (write_hit) begin
      dirty_reg[index] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (state_reg == UPDATE)
      tag_mem[miss_index] <= miss_tag;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      miss_block_reg <= '0;
      fill_data_reg  <= '0;
    end else begin
      if (miss_start)
        miss_block_reg <= bus.ADDRESS[7:2];
      if (state_reg == FETCH && !bus.MEM_BUSYWAIT)
        fill_data_reg <= bus.MEM_READDATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (request && !hit)
          state_next = (valid_reg[index] && dirty_reg[index]) ? WRITEBACK : FETCH;
      end
      WRITEBACK: if (!bus.MEM_BUSYWAIT) state_next = FETCH;
      FETCH:     if (!bus.MEM_BUSYWAIT) state_next = UPDATE;
      UPDATE:    state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.MEM_READ      = 1'b0;
    bus.MEM_WRITE     = 1'b0;
    bus.MEM_ADDRESS   = '0;
    bus.MEM_WRITEDATA = '0;
    bus.BUSYWAIT      = request && !(idle && hit);
    // Gated by hit so an untouched line after reset reads as zero.
    bus.READDATA      = (idle && hit) ? lane_rd[offset] : 8'h00;
    case (state_reg)
      WRITEBACK: begin
        bus.MEM_WRITE     = 1'b1;
        bus.MEM_ADDRESS   = {tag_mem[miss_index], miss_index};
        bus.MEM_WRITEDATA = {lane_victim[3], lane_victim[2], lane_victim[1], lane_victim[0]};
      end
      FETCH: begin
        bus.MEM_READ    = 1'b1;
        bus.MEM_ADDRESS = miss_block_reg;
      end
      default: ;
    endcase
  end

`ifdef DCACHE_STATS_EN
  // The access that completes right after a fill is the tail of a miss, not a first-lookup hit.
  logic        filled_reg;
  logic [15:0] hit_count_reg;
  logic [15:0] miss_count_reg;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      filled_reg     <= 1'b0;
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else begin
      if (state_reg == UPDATE) filled_reg <= 1'b1;
      else if (idle)           filled_reg <= 1'b0;
      if (idle && request && hit && !filled_reg && hit_count_reg != 16'hFFFF)
        hit_count_reg <= hit_count_reg + 16'd1;
      if (miss_start && miss_count_reg != 16'hFFFF)
        miss_count_reg <= miss_count_reg + 16'd1;
    end
  end

  assign HIT_COUNT  = hit_count_reg;
  assign MISS_COUNT = miss_count_reg;
`endif
endmodule

// File: tb/tb_dcache.sv
// Scoreboard bench for dcache: directed accesses push expected CPU and memory transactions,
// independent monitors pop and compare them when the cache completes each one.
module tb_dcache;
  logic CLK = 1'b0;
  logic RESET;
  dcache_if bus();

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  dcache #(.INDEX_BITS(3)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus)
`ifdef DCACHE_STATS_EN
    ,
    .HIT_COUNT(hit_count),
    .MISS_COUNT(miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit         is_write;
    logic [7:0] addr;
    logic [7:0] rdata;
    int         stalls;
  } cpu_exp_t;

  typedef struct {
    bit          is_write;
    logic [5:0]  addr;
    logic [31:0] wdata;
  } mem_exp_t;

  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mem [64];
  int mem_latency = 5;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Main memory: busy for mem_latency sampled edges of a held request, then one ready edge.
  initial begin : mem_model
    int cnt;
    cnt = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[6'h05] = 32'hDDCCBBAA;
    mem[6'h0D] = 32'h44332211;
    mem[6'h38] = 32'h87654321;
    mem[6'h00] = 32'h0F0E0D0C;
    bus.MEM_BUSYWAIT = 1'b1;
    bus.MEM_READDATA = 32'h0;
    forever begin
      @(negedge CLK);
      if (RESET || !(bus.MEM_READ || bus.MEM_WRITE)) begin
        cnt = 0;
        bus.MEM_BUSYWAIT = 1'b1;
      end else if (cnt < mem_latency) begin
        cnt++;
        bus.MEM_BUSYWAIT = 1'b1;
      end else begin
        cnt = 0;
        bus.MEM_BUSYWAIT = 1'b0;
        if (bus.MEM_READ)  bus.MEM_READDATA = mem[bus.MEM_ADDRESS];
        if (bus.MEM_WRITE) mem[bus.MEM_ADDRESS] = bus.MEM_WRITEDATA;
      end
    end
  end

  initial begin : cpu_monitor
    int stall_cnt;
    cpu_exp_t e;
    stall_cnt = 0;
    forever begin
      @(negedge CLK);
      if (!RESET && (bus.READ || bus.WRITE)) begin
        if (bus.BUSYWAIT) begin
          stall_cnt++;
        end else begin
          if (cpu_q.size() == 0) begin
            check("cpu_unexpected", 32'd1, 32'd0);
          end else begin
            e = cpu_q.pop_front();
            check("cpu_addr", {24'h0, bus.ADDRESS}, {24'h0, e.addr});
            if (!e.is_write) check("cpu_rdata", {24'h0, bus.READDATA}, {24'h0, e.rdata});
            check("cpu_stalls", stall_cnt, e.stalls);
          end
          stall_cnt = 0;
        end
      end else begin
        stall_cnt = 0;
      end
    end
  end

  initial begin : mem_monitor
    mem_exp_t e;
    forever begin
      @(negedge CLK);
      #1;
      if (!RESET && (bus.MEM_READ || bus.MEM_WRITE) && !bus.MEM_BUSYWAIT) begin
        if (mem_q.size() == 0) begin
          check("mem_unexpected", {26'h0, bus.MEM_ADDRESS}, 32'hFFFFFFFF);
        end else begin
          e = mem_q.pop_front();
          check("mem_kind", {31'h0, bus.MEM_WRITE}, {31'h0, e.is_write});
          check("mem_excl", {31'h0, bus.MEM_READ & bus.MEM_WRITE}, 32'd0);
          check("mem_addr", {26'h0, bus.MEM_ADDRESS}, {26'h0, e.addr});
          if (e.is_write) check("mem_wdata", bus.MEM_WRITEDATA, e.wdata);
        end
      end
    end
  end

  task automatic push_mem(input bit is_write, input logic [5:0] addr, input logic [31:0] wdata);
    mem_exp_t e;
    e.is_write = is_write;
    e.addr     = addr;
    e.wdata    = wdata;
    mem_q.push_back(e);
  endtask

  // Starts and ends just after a rising edge; holds the request until BUSYWAIT is seen low.
  task automatic access(input bit is_write, input logic [7:0] addr, input logic [7:0] wdata,
                        input logic [7:0] exp_rdata, input int exp_stalls, input int latency);
    cpu_exp_t e;
    int n;
    e.is_write = is_write;
    e.addr     = addr;
    e.rdata    = exp_rdata;
    e.stalls   = exp_stalls;
    cpu_q.push_back(e);
    mem_latency   = latency;
    bus.ADDRESS   = addr;
    bus.WRITEDATA = wdata;
    bus.READ      = !is_write;
    bus.WRITE     = is_write;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (bus.BUSYWAIT && n < 100);
    if (bus.BUSYWAIT) check("cpu_timeout", 32'd1, 32'd0);
    @(posedge CLK);
    #1;
    bus.READ  = 1'b0;
    bus.WRITE = 1'b0;
  endtask

  task automatic check_stats(input int hits, input int misses);
`ifdef DCACHE_STATS_EN
    check("hit_count", {16'h0, hit_count}, hits);
    check("miss_count", {16'h0, miss_count}, misses);
`endif
  endtask

  initial begin : stimulus
    RESET = 1'b1;
    bus.READ = 1'b0;
    bus.WRITE = 1'b0;
    bus.ADDRESS = 8'h00;
    bus.WRITEDATA = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_readdata", {24'h0, bus.READDATA}, 32'd0);
    check("rst_busywait", {31'h0, bus.BUSYWAIT}, 32'd0);
    check("rst_mem_read", {31'h0, bus.MEM_READ}, 32'd0);
    check("rst_mem_write", {31'h0, bus.MEM_WRITE}, 32'd0);
    check("rst_mem_address", {26'h0, bus.MEM_ADDRESS}, 32'd0);
    check("rst_mem_wdata", bus.MEM_WRITEDATA, 32'd0);
    check_stats(0, 0);
    RESET = 1'b0;

    // Cold read miss, memory busy 5 edges: 1 detect + 6 fetch + 1 update stall cycles.
    push_mem(1'b0, 6'h05, 32'h0);
    access(1'b0, 8'h14, 8'h00, 8'hAA, 8, 5);
    access(1'b0, 8'h16, 8'h00, 8'hCC, 0, 5);
    access(1'b1, 8'h15, 8'h5A, 8'h00, 0, 5);
    // Conflict on index 5 with a dirty victim: writeback then fetch.
    push_mem(1'b1, 6'h05, 32'hDDCC5AAA);
    push_mem(1'b0, 6'h0D, 32'h0);
    access(1'b0, 8'h34, 8'h00, 8'h11, 14, 5);
    check_stats(2, 2);

    // Write miss into a clean (invalid) line, then confirm the merged byte.
    push_mem(1'b0, 6'h38, 32'h0);
    access(1'b1, 8'hE3, 8'hA7, 8'h00, 5, 2);
    access(1'b0, 8'hE3, 8'h00, 8'hA7, 0, 2);
    // Conflict on index 0 with zero-latency memory evicts the stored block.
    push_mem(1'b1, 6'h38, 32'hA7654321);
    push_mem(1'b0, 6'h00, 32'h0);
    access(1'b0, 8'h03, 8'h00, 8'h0F, 4, 0);
    access(1'b0, 8'h01, 8'h00, 8'h0D, 0, 0);
    check_stats(4, 4);

    // Reset in the middle of a fetch aborts it without a memory transaction.
    mem_latency = 5;
    bus.ADDRESS = 8'h14;
    bus.READ    = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("fetch_in_flight", {31'h0, bus.MEM_READ}, 32'd1);
    RESET    = 1'b1;
    bus.READ = 1'b0;
    @(posedge CLK);
    #1;
    check("abort_mem_read", {31'h0, bus.MEM_READ}, 32'd0);
    check("abort_busywait", {31'h0, bus.BUSYWAIT}, 32'd0);
    check("abort_readdata", {24'h0, bus.READDATA}, 32'd0);
    check_stats(0, 0);
    RESET = 1'b0;

    // All lines invalid again: 0x14 misses and refetches the written-back block 5.
    push_mem(1'b0, 6'h05, 32'h0);
    access(1'b0, 8'h14, 8'h00, 8'hAA, 4, 1);
    access(1'b0, 8'h15, 8'h00, 8'h5A, 0, 1);
    check_stats(1, 1);

    repeat (5) @(posedge CLK);
    #1;
    check("cpu_q_drained", cpu_q.size(), 32'd0);
    check("mem_q_drained", mem_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end
endmodule
